// File: rtl/lmt_writer_if.sv
// Memory write port between the LMT writer and the arbitrated memory.
// Beats complete on the clock edge where mem_req and mem_gnt are both high.
interface lmt_writer_if;
  logic        mem_req;
  logic        mem_gnt;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_wen;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_din,
    output mem_wen,
    input  mem_gnt
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_din,
    input  mem_wen,
    output mem_gnt
  );
endinterface

// File: rtl/lmt_writer.sv
// Free-running timestamp counter; each upLMT rising edge snapshots the counter and writes
// it into the LMT region as little-endian 16-bit words over a req/gnt write port.
module lmt_writer #(
  parameter logic [15:0] LMT_BASE  = 16'h0040,
  parameter int unsigned LMT_WORDS = 4,
  parameter int unsigned CNT_W     = 64,
  parameter logic [15:0] PRESCALE  = 16'd1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             upLMT,
  lmt_writer_if.master     mem,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] lmt_cnt
);
  localparam int unsigned PadW = 16 * LMT_WORDS;
  localparam int unsigned IdxW = (LMT_WORDS > 1) ? $clog2(LMT_WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(LMT_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [15:0]       presc_q, presc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  snap_q, snap_d;
  logic [CNT_W-1:0]  lmt_cnt_q, lmt_cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              pending_q, pending_d;
  logic              uplmt_q;
  logic              rise;
  logic              req;
  logic [PadW-1:0]   snap_ext;

  assign rise = upLMT & ~uplmt_q;

  // Counter never stalls, including while an update is being written.
  always_comb begin
    presc_d = presc_q + 16'd1;
    cnt_d   = cnt_q;
    if (presc_q == PRESCALE - 16'd1) begin
      presc_d = '0;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    lmt_cnt_d = lmt_cnt_q;
    pending_d = pending_q;
    unique case (state_q)
      StIdle: begin
        if (rise || pending_q) begin
          snap_d    = cnt_q;
          idx_d     = '0;
          pending_d = 1'b0;
          state_d   = StWrite;
        end
      end
      StWrite: begin
        if (rise) pending_d = 1'b1;
        if (mem.mem_gnt) begin
          if (idx_q == LastIdx) begin
            lmt_cnt_d = snap_q;
            state_d   = StDone;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDone: begin
        // A rise coinciding with the follow-up snapshot is served by that snapshot.
        if (pending_q) begin
          snap_d    = cnt_q;
          idx_d     = '0;
          pending_d = 1'b0;
          state_d   = StWrite;
        end else begin
          pending_d = rise;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      cnt_q     <= '0;
      snap_q    <= '0;
      lmt_cnt_q <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      uplmt_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      lmt_cnt_q <= lmt_cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      uplmt_q   <= upLMT;
    end
  end

  // Words beyond CNT_W read as zero.
  assign snap_ext     = PadW'(snap_q);
  assign req          = (state_q == StWrite);
  assign mem.mem_req  = req;
  assign mem.mem_wen  = {2{req}};
  assign mem.mem_addr = LMT_BASE + (16'(idx_q) << 1);
  assign mem.mem_din  = snap_ext[16*idx_q +: 16];
  assign busy         = req;
  assign done         = (state_q == StDone);
  assign lmt_cnt      = lmt_cnt_q;
endmodule

// File: tb/tb_lmt_writer.sv
// Scoreboard bench for lmt_writer: stimulus queues expected beats and LMT values,
// a negedge monitor pops and compares them as the DUT presents grants and done pulses.
module tb_lmt_writer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        up0, up6;
  logic        busy0, done0, busy6, done6;
  logic [63:0] lmt0, lmt6;

  int checks   = 0;
  int failures = 0;

  lmt_writer_if m0 ();
  lmt_writer_if m6 ();

  always #5 clk = ~clk;

  lmt_writer u0 (
    .clk     (clk),
    .reset_n (reset_n),
    .upLMT   (up0),
    .mem     (m0),
    .busy    (busy0),
    .done    (done0),
    .lmt_cnt (lmt0)
  );

  lmt_writer #(.PRESCALE(16'd3)) u6 (
    .clk     (clk),
    .reset_n (reset_n),
    .upLMT   (up6),
    .mem     (m6),
    .busy    (busy6),
    .done    (done6),
    .lmt_cnt (lmt6)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } beat_t;

  beat_t       exp_beats[$];
  logic [63:0] exp_lmt[$];
  beat_t       b;

  // Reference counters: PRESCALE=1 instance and increment count of the PRESCALE=3 one.
  logic [63:0] cnt0;
  logic [1:0]  p6;
  logic [63:0] inc6;
  logic [63:0] base6, inc_base;
  bit          chk6_en;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt0 <= '0;
    else          cnt0 <= cnt0 + 64'd1;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p6   <= '0;
      inc6 <= '0;
    end else if (p6 == 2'd2) begin
      p6   <= '0;
      inc6 <= inc6 + 64'd1;
    end else begin
      p6 <= p6 + 2'd1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_update(input logic [63:0] s, input int nbeats, input bit with_lmt);
    beat_t nb;
    for (int i = 0; i < nbeats; i++) begin
      nb.addr = 16'(16'h0040 + 2 * i);
      nb.data = s[16*i +: 16];
      exp_beats.push_back(nb);
    end
    if (with_lmt) exp_lmt.push_back(s);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      chk("wen_enc", {62'd0, m0.mem_wen}, m0.mem_req ? 64'd3 : 64'd0);
      if (m0.mem_req && m0.mem_gnt) begin
        if (exp_beats.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h/%0h required=none", m0.mem_addr, m0.mem_din);
        end else begin
          b = exp_beats.pop_front();
          chk("beat_addr", m0.mem_addr, b.addr);
          chk("beat_din", m0.mem_din, b.data);
        end
      end
      if (done0) begin
        if (exp_lmt.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=%0h required=none", lmt0);
        end else begin
          chk("done_lmt", lmt0, exp_lmt.pop_front());
        end
        chk("done_busy", busy0, 0);
      end
    end
    if (chk6_en) chk("cnt6", u6.cnt_q, base6 + (inc6 - inc_base));
  end

  task automatic upd6(input logic [63:0] s);
    int  k;
    bit  seen;
    tick(1);
    up6 = 1'b0;
    k   = 0;
    for (int i = 0; i < 20 && k < 4; i++) begin
      @(negedge clk);
      if (m6.mem_req && m6.mem_gnt) begin
        chk("t6_addr", m6.mem_addr, 64'(16'h0040 + 2 * k));
        chk("t6_din", m6.mem_din, s[16*k +: 16]);
        k++;
      end
    end
    chk("t6_beats", k, 4);
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (done6) seen = 1'b1;
    end
    chk("t6_done", seen, 1);
    chk("t6_lmt", lmt6, s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] c;
    int          n, busy_cnt, dn;
    bit          seen;
    reset_n    = 1'b0;
    up0        = 1'b0;
    up6        = 1'b0;
    m0.mem_gnt = 1'b0;
    m6.mem_gnt = 1'b1;
    chk6_en    = 1'b0;
    base6      = '0;
    inc_base   = '0;
    #12;
    chk("rst_req", m0.mem_req, 0);
    chk("rst_wen", m0.mem_wen, 0);
    chk("rst_addr", m0.mem_addr, 16'h0040);
    chk("rst_din", m0.mem_din, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_lmt", lmt0, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Idle after reset
    tick(10);
    @(negedge clk);
    chk("idle_req", m0.mem_req, 0);
    chk("idle_busy", busy0, 0);
    chk("idle_done", done0, 0);
    chk("idle_cnt", u0.cnt_q, 64'd10);

    // Single update, grant always high; upLMT held high must yield one request
    m0.mem_gnt = 1'b1;
    n = 0;
    while (cnt0 != 64'h25 && n < 100) begin
      tick(1);
      n++;
    end
    c = cnt0;
    push_update(c, 4, 1'b1);
    up0 = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_beat_cycle", m0.mem_req & m0.mem_gnt, 1);
    end
    @(negedge clk);
    chk("t2_done", done0, 1);
    tick(6);
    chk("t2_lmt", lmt0, 64'h25);
    up0 = 1'b0;

    // Grant withheld for 5 cycles on beat 1
    tick(3);
    c = cnt0;
    push_update(c, 4, 1'b1);
    up0 = 1'b1;
    tick(1);
    up0      = 1'b0;
    busy_cnt = 0;
    @(negedge clk);
    busy_cnt += int'(busy0);
    @(posedge clk);
    #1 m0.mem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_addr_hold", m0.mem_addr, 16'h0042);
      chk("t3_din_hold", m0.mem_din, c[31:16]);
      chk("t3_req_hold", m0.mem_req, 1);
      busy_cnt += int'(busy0);
    end
    @(posedge clk);
    #1 m0.mem_gnt = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done0) seen = 1'b1;
      else       busy_cnt += int'(busy0);
    end
    chk("t3_done_seen", seen, 1);
    chk("t3_busy_cycles", busy_cnt, 9);

    // Three pulses in one update (last on the final grant) -> one follow-up
    tick(2);
    c = cnt0;
    push_update(c, 4, 1'b1);
    push_update(c + 64'd5, 4, 1'b1);
    up0 = 1'b1;
    tick(1);
    up0 = 1'b0;
    tick(1);
    up0 = 1'b1;
    tick(1);
    up0 = 1'b0;
    tick(1);
    up0 = 1'b1;
    tick(1);
    up0 = 1'b0;
    dn  = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      dn += int'(done0);
    end
    chk("t4_done_pulses", dn, 2);
    chk("t4_sb_drained", exp_beats.size(), 0);

    // Reset after beat 1 granted
    tick(3);
    c = cnt0;
    push_update(c, 2, 1'b0);
    up0 = 1'b1;
    tick(1);
    up0 = 1'b0;
    tick(2);
    reset_n = 1'b0;
    #1;
    chk("t5_req_async", m0.mem_req, 0);
    chk("t5_wen_async", m0.mem_wen, 0);
    chk("t5_busy", busy0, 0);
    chk("t5_lmt", lmt0, 0);
    chk("t5_partial", exp_beats.size(), 0);
    tick(2);
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n += int'(m0.mem_req);
    end
    chk("t5_no_resume", n, 0);

    // PRESCALE=3 instance: preset near wrap, all-ones snapshot, then zero after wrap
    @(posedge clk);
    #1 force u6.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release u6.cnt_q;
    base6    = 64'hFFFF_FFFF_FFFF_FFFF;
    inc_base = inc6;
    chk6_en  = 1'b1;
    up6      = 1'b1;
    upd6(64'hFFFF_FFFF_FFFF_FFFF);
    tick(1);
    chk6_en = 1'b0;
    force u6.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release u6.cnt_q;
    base6    = 64'hFFFF_FFFF_FFFF_FFFF;
    inc_base = inc6;
    chk6_en  = 1'b1;
    n = 0;
    while ((base6 + (inc6 - inc_base)) != 64'd0 && n < 10) begin
      tick(1);
      n++;
    end
    up6 = 1'b1;
    upd6(64'd0);
    tick(4);
    chk6_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
